// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 memory manager.
// Holds the H/K init tables, memory region bases and the FSM state enum.
package sha256_pkg;

    localparam int MEM_DEPTH = 128;

    localparam logic [6:0] H_BASE    = 7'd0;
    localparam logic [6:0] K_BASE    = 7'd8;
    localparam logic [6:0] FREE_BASE = 7'd72;

    localparam logic [31:0] H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sha256_const_rom.sv
// Combinational init-word map: address -> H, K or zero.
// Ports: addr_i (7-bit word address), word_o (32-bit init word).
module sha256_const_rom
    import sha256_pkg::*;
(
    input  logic [6:0]  addr_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        if (addr_i < K_BASE) begin
            word_o = H_INIT[addr_i[2:0]];
        end else if (addr_i < FREE_BASE) begin
            word_o = K[6'(addr_i - K_BASE)];
        end
    end

endmodule

// File: rtl/memmgr.sv
// SHA-256 working memory with init sequencer and registered read port.
// Ports: CLK, RST, INIT/INIT_COMPLETE handshake, RD_ADDR -> RD_DATA.
module memmgr
    import sha256_pkg::state_e;
    import sha256_pkg::IDLE;
    import sha256_pkg::FILL;
    import sha256_pkg::DONE;
#(
    parameter int MEM_DEPTH = 128,
    parameter int ADDR_W    = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INIT,
    output logic              INIT_COMPLETE,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [31:0]       RD_DATA
);

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  addr_d;
    logic               cmp_q;
    logic [31:0]        rd_q;
    logic [31:0]        rom_word;
    logic               we;
    logic               last;
    logic [31:0]        mem_q [MEM_DEPTH];

    sha256_const_rom u_rom (
        .addr_i (addr_q),
        .word_o (rom_word)
    );

    assign addr_d = addr_q + ADDR_W'(1);
    assign last   = (addr_q == ADDR_W'(MEM_DEPTH - 1));
    // Reset wins over a pending fill write, leaving memory partially filled.
    assign we     = (state_q == FILL) && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cmp_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (INIT) begin
                        state_q <= FILL;
                        addr_q  <= '0;
                    end
                end
                FILL: begin
                    addr_q <= addr_d;
                    if (last) begin
                        state_q <= DONE;
                        cmp_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (!INIT) begin
                        state_q <= IDLE;
                        cmp_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cmp_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[addr_q] <= rom_word;
        end
    end

    // Non-blocking read gives old contents on a same-address fill write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem_q[RD_ADDR];
        end
    end

    assign INIT_COMPLETE = cmp_q;
    assign RD_DATA       = rd_q;

endmodule

// File: tb/tb_memmgr.sv
// Self-checking bench for memmgr: behavioural memory/handshake model
// compared every cycle, plus literal checks of latency and contents.
module tb_memmgr;

    logic        clk;
    logic        rst;
    logic        init;
    logic        init_complete;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;

    int checks;
    int failures;

    memmgr #(.MEM_DEPTH(128), .ADDR_W(7)) dut (
        .CLK           (clk),
        .RST           (rst),
        .INIT          (init),
        .INIT_COMPLETE (init_complete),
        .RD_ADDR       (rd_addr),
        .RD_DATA       (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] tbl [0:71] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] init_word(input int a);
        return (a < 72) ? tbl[a] : 32'h0;
    endfunction

    // Behavioural model: fill progress as a plain counter, memory as array.
    logic [31:0] m_mem   [0:127];
    bit          m_known [0:127];
    bit          m_busy;
    int          m_cnt;
    bit          m_cmp;
    logic [31:0] m_rd;
    bit          m_rd_known;

    initial begin
        for (int i = 0; i < 128; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = '0;
        end
        m_busy     = 1'b0;
        m_cnt      = 0;
        m_cmp      = 1'b0;
        m_rd       = '0;
        m_rd_known = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_busy     = 1'b0;
            m_cnt      = 0;
            m_cmp      = 1'b0;
            m_rd       = '0;
            m_rd_known = 1'b1;
        end else begin
            m_rd       = m_mem[rd_addr];
            m_rd_known = m_known[rd_addr];
            if (m_busy) begin
                m_mem[m_cnt]   = init_word(m_cnt);
                m_known[m_cnt] = 1'b1;
                m_cnt++;
                if (m_cnt == 128) begin
                    m_busy = 1'b0;
                    m_cmp  = 1'b1;
                end
            end else if (m_cmp) begin
                if (!init) m_cmp = 1'b0;
            end else if (init) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (init_complete !== m_cmp) begin
                failures++;
                $display("FAIL init_complete: got %0b want %0b t=%0t",
                         init_complete, m_cmp, $time);
            end
            if (m_rd_known) begin
                checks++;
                if (rd_data !== m_rd) begin
                    failures++;
                    $display("FAIL rd_data: got %h want %h addr=%0d t=%0t",
                             rd_data, m_rd, rd_addr, $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Raise INIT and wait for completion; returns edges from sampling edge.
    task automatic do_fill(input int drop_at, output int lat);
        lat = -1;
        init = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 23) chk("rbw_next_k12", rd_data, 32'h72be5d74);
            if (init_complete) begin
                lat = n - 1;
                break;
            end
            rd_addr = ((n == 21) || (n == 22)) ? 7'd20 : 7'($urandom_range(0, 127));
            if (n == drop_at) init = 1'b0;
        end
        if (lat < 0) begin
            failures++;
            checks++;
            $display("FAIL fill_timeout: got none want 128");
        end
    endtask

    int lat;
    int ra [6] = '{0, 7, 8, 71, 72, 127};
    logic [31:0] rv [6] = '{32'h6a09e667, 32'h5be0cd19, 32'h428a2f98,
                            32'hc67178f2, 32'h0, 32'h0};

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        init     = 1'b0;
        rd_addr  = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_complete", {31'b0, init_complete}, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            rd_addr = 7'($urandom_range(0, 127));
        end
        chk("idle_complete", {31'b0, init_complete}, 32'h0);

        // Reset in the middle of a fill: addr 0..49 written, rest aborted.
        init = 1'b1;
        for (int n = 1; n <= 51; n++) begin
            @(negedge clk);
            rd_addr = 7'($urandom_range(0, 127));
        end
        rst  = 1'b1;
        init = 1'b0;
        @(negedge clk);
        chk("abort_complete", {31'b0, init_complete}, 32'h0);
        rst = 1'b0;
        for (int a = 0; a < 50; a++) begin
            rd_addr = 7'(a);
            @(negedge clk);
        end
        chk("abort_addr49", rd_data, 32'ha81a664b);
        repeat (10) @(negedge clk);
        chk("abort_idle", {31'b0, init_complete}, 32'h0);

        // Full fill, hold INIT one extra cycle, then drop.
        do_fill(0, lat);
        chk("latency_1", 32'(lat), 32'd128);
        @(negedge clk);
        chk("hold_complete", {31'b0, init_complete}, 32'h1);
        init = 1'b0;
        @(negedge clk);
        chk("drop_complete", {31'b0, init_complete}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            rd_addr = 7'(ra[i]);
            @(negedge clk);
            chk($sformatf("readback_%0d", ra[i]), rd_data, rv[i]);
        end

        // Second request re-runs with the same latency.
        do_fill(0, lat);
        chk("latency_2", 32'(lat), 32'd128);
        init = 1'b0;
        @(negedge clk);
        chk("drop2_complete", {31'b0, init_complete}, 32'h0);

        // INIT dropped at fill cycle 10: fill completes, one-cycle pulse.
        do_fill(10, lat);
        chk("latency_drop10", 32'(lat), 32'd128);
        @(negedge clk);
        chk("pulse_end", {31'b0, init_complete}, 32'h0);

        repeat (200) begin
            rd_addr = 7'($urandom_range(0, 127));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memmgr.md
# memmgr

Memory manager for the SHA-256 core. It owns the 128×32-bit working memory. On request it runs an init sequence that loads the initial hash values H0..H7 and the 64 round constants K0..K63, and zero-fills the rest. It then signals completion to the controller. Downstream datapath stages read the memory through a registered read port.

## Interface
Parameters:
- `MEM_DEPTH`, default 128: number of 32-bit words. Fixed at 128; must be at least 72.
- `ADDR_W`, default 7: address width, equal to log2(`MEM_DEPTH`).

Ports:
- `CLK` input, 1: single clock; all logic is on the rising edge.
- `RST` input, 1: reset, synchronous and active-high.
- `INIT` input, 1: level request to run the init sequence. The requester holds it high until `INIT_COMPLETE` rises, then drops it.
- `INIT_COMPLETE` output, 1: registered. High from end of fill until `INIT` is seen low.
- `RD_ADDR` input, `ADDR_W`: read address.
- `RD_DATA` output, 32: registered read data.

## Operation
- FSM states:
  - IDLE (reset state)
  - FILL
  - DONE
- IDLE to FILL: when `INIT`=1 is sampled. The fill address counter is set to 0.
- FILL writes one word per cycle, `mem[addr]` = init word for `addr`, then `addr` increments. Init words:
  - addr 0..7: H0..H7, i.e. 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
  - addr 8..71: K0..K63 in standard FIPS 180-4 order, with K0=428a2f98 at addr 8 and K63=c67178f2 at addr 71.
  - addr 72..127: 00000000.
- The cycle that writes addr 127 moves the FSM to DONE and sets `INIT_COMPLETE`=1.
- Dropping `INIT` during FILL does not abort. The fill always runs to completion.
- In DONE, `INIT_COMPLETE` stays 1 while `INIT`=1.
- DONE to IDLE: when `INIT`=0 is sampled; `INIT_COMPLETE` clears on that edge.
- `INIT` still high on re-entry to IDLE is impossible, because DONE waits for `INIT` low. A new rising request re-runs the full fill.
- Reads are allowed in every state: `RD_DATA` <= `mem[RD_ADDR]` every cycle.
- Read and fill-write to the same address in the same cycle: read-before-write, so `RD_DATA` returns the old contents.

## Timing
- Reset values: state=IDLE, `INIT_COMPLETE`=0, `RD_DATA`=0, fill address=0. Memory contents are not cleared by reset; they are undefined until the first completed fill.
- Reset has priority over all other activity. `RST` during FILL aborts the fill, and the memory is partially written.
- Latency:
  - Let edge E be the edge that samples `INIT`=1 in IDLE.
  - The writes to addr 0..127 occur on edges E+1..E+128.
  - `INIT_COMPLETE` is high after edge E+128.
  - If `INIT` is seen low at edge F, `INIT_COMPLETE` is low after edge F.
- Read latency is 1 cycle. The read address is sampled at edge N, and data is valid after edge N.
- A word written at edge N is readable with data valid after edge N+1.

## Structure
- Package `sha256_pkg` holds:
  - `H_INIT[0:7]` and `K[0:63]` as 32-bit constant arrays.
  - `MEM_DEPTH`, and the region bases `H_BASE`=0, `K_BASE`=8, `FREE_BASE`=72.
  - The FSM state enum {IDLE, FILL, DONE}.
- One sub-module, `sha256_const_rom`: a combinational map from a 7-bit address to the init word using the package constants.
- The top level holds the FSM, the address counter, the memory array (inferred single-write/single-read RAM) and the read register.

## Test plan
- Reset, then idle: `INIT_COMPLETE`=0 and `RD_DATA`=0 after reset. No state change while `INIT`=0.
- `INIT` raised and held until `INIT_COMPLETE`: `INIT_COMPLETE` rises exactly 128 cycles after the sampling edge. Readback gives addr 0 = 6a09e667, addr 7 = 5be0cd19, addr 8 = 428a2f98, addr 71 = c67178f2, addr 72 and addr 127 = 00000000.
- Drop `INIT` one cycle after `INIT_COMPLETE` rises: `INIT_COMPLETE` falls on the next edge and the FSM returns to IDLE. A second `INIT` pulse re-runs the fill with the same 128-cycle latency.
- Drop `INIT` at fill cycle 10: the fill continues to completion, `INIT_COMPLETE` pulses for one cycle, then the FSM returns to IDLE.
- Assert `RST` at fill cycle 50: `INIT_COMPLETE` stays 0, the FSM goes to IDLE, and addr 0..49 already hold their correct init values.
- Read addr 20 while it is being written during fill: `RD_DATA` shows the old value, then K12=72be5d74 on the next read.
